// File: rtl/systolic_writeback.sv
// rtl/systolic_writeback.sv - drains systolic array result rows into the output SRAM
// Optional clamp-before-truncate conversion enabled with WB_SATURATE_EN.
module systolic_writeback #(
  parameter int datawith   = 16,
  parameter int array_size = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             write_start,
  input  logic [5:0]                       matrix_index,
  input  logic                             row_valid,
  input  logic [array_size*2*datawith-1:0] row_data,
  output logic                             row_ready,
  output logic                             sram_write_enable,
  output logic [6:0]                       sram_waddr,
  output logic [array_size*datawith-1:0]   sram_wdata,
  output logic                             write_busy,
  output logic                             write_done
);

  localparam int AW = 2 * datawith;
  localparam int CW = $clog2(array_size) + 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(array_size - 1);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

  state_t                         state_q, state_d;
  logic [CW-1:0]                  row_cnt_q, row_cnt_d;
  logic [5:0]                     base_q, base_d;
  logic                           row_ready_q, row_ready_d;
  logic                           we_q, we_d;
  logic [6:0]                     waddr_q, waddr_d;
  logic [array_size*datawith-1:0] wdata_q, wdata_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [array_size*datawith-1:0] conv_row;

`ifdef WB_SATURATE_EN
  logic [datawith:0] sat_hi;

  // A lane fits iff its top datawith+1 bits are all equal (pure sign extension).
  always_comb begin
    conv_row = '0;
    sat_hi   = '0;
    for (int i = 0; i < array_size; i++) begin
      sat_hi = row_data[i*AW+datawith-1 +: datawith+1];
      if (sat_hi == '0 || sat_hi == '1)
        conv_row[i*datawith +: datawith] = row_data[i*AW +: datawith];
      else if (row_data[i*AW+AW-1])
        conv_row[i*datawith +: datawith] = {1'b1, {(datawith-1){1'b0}}};
      else
        conv_row[i*datawith +: datawith] = {1'b0, {(datawith-1){1'b1}}};
    end
  end
`else
  logic unused_acc_hi;

  always_comb begin
    conv_row      = '0;
    unused_acc_hi = 1'b0;
    for (int i = 0; i < array_size; i++) begin
      conv_row[i*datawith +: datawith] = row_data[i*AW +: datawith];
      unused_acc_hi = unused_acc_hi ^ (^row_data[i*AW+datawith +: datawith]);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    base_d      = base_q;
    row_ready_d = row_ready_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (write_start) begin
          state_d     = RECV;
          base_d      = matrix_index;
          row_cnt_d   = '0;
          row_ready_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      RECV: begin
        if (row_valid && row_ready_q) begin
          we_d      = 1'b1;
          waddr_d   = {1'b0, base_q} + 7'(row_cnt_q);
          wdata_d   = conv_row;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == LAST_ROW) begin
            state_d     = FLUSH;
            row_ready_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      base_q      <= '0;
      row_ready_q <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      base_q      <= base_d;
      row_ready_q <= row_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign row_ready         = row_ready_q;
  assign sram_write_enable = we_q;
  assign sram_waddr        = waddr_q;
  assign sram_wdata        = wdata_q;
  assign write_busy        = busy_q;
  assign write_done        = done_q;

endmodule

// File: doc/systolic_writeback.md
# systolic_writeback

Result drain engine for the systolic array. When the controller enters its write phase, this block receives PE results from the array one row at a time over a valid/ready handshake. It converts each 2×datawith accumulator lane to datawith, writes one packed row per cycle into the output SRAM, and signals completion back to the controller.

## Interface
Parameters:
- datawith, 16, width of one output element; accumulator lanes are 2*datawith
- array_size, 8, PEs per row; also the number of rows per drain

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- write_start  input  1  one-cycle pulse from the controller that starts a drain
- matrix_index  input  6  base SRAM row address; sampled on the accepted write_start
- row_valid  input  1  array presents a valid result row
- row_data  input  array_size*2*datawith  signed accumulator lanes; lane i is bits [i*2*datawith +: 2*datawith]
- row_ready  output  1  block accepts a row this cycle
- sram_write_enable  output  1  one-cycle write strobe
- sram_waddr  output  7  write address
- sram_wdata  output  array_size*datawith  packed converted row; lane i is bits [i*datawith +: datawith]
- write_busy  output  1  high from the accepted write_start until write_done
- write_done  output  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: row_ready=0. Waits for write_start.
  - RECV: row_ready=1. Accepts rows.
  - FLUSH: row_ready=0. Completes the final SRAM write.
  - DONE: pulses write_done for one cycle.
- Transitions:
  - IDLE → RECV on write_start. Latch base=matrix_index and clear row_cnt.
  - RECV → FLUSH on the handshake (row_valid & row_ready) that carries row array_size-1.
  - FLUSH → DONE after one cycle.
  - DONE → IDLE after one cycle.
- Each handshake does three things:
  - converts all lanes and registers them into sram_wdata
  - sets sram_waddr = (base + row_cnt) mod 128
  - asserts sram_write_enable for the next cycle, then increments row_cnt
- Throughput: one row per cycle. There is no backpressure inside RECV.
- row_valid is ignored outside RECV. write_start is ignored outside IDLE; there is no restart.
- Address wrap: base + row_cnt wraps modulo 128. For example, base=63 with row_cnt 0..7 gives addresses 63..70; 7-bit wrap occurs only if extended bases are used. The sum is computed in 7 bits.
- row_cnt is log2(array_size)+1 bits wide and holds at array_size after the last row.
- sram_wdata holds its last value when no write occurs.

## Timing
- Reset values:
  - state=IDLE, row_cnt=0, base=0
  - row_ready=0, sram_write_enable=0, sram_waddr=0, sram_wdata=0
  - write_busy=0, write_done=0
- write_start sampled at edge T: row_ready=1 from cycle T+1.
- Row accepted at edge N: sram_write_enable, sram_waddr and sram_wdata are valid during cycle N+1.
- Last row accepted at edge L:
  - final write occurs in cycle L+1 (FLUSH)
  - write_done=1 in cycle L+2 (DONE)
  - write_busy falls with write_done
- Minimum drain with row_valid held high: array_size + 3 cycles from write_start to write_done inclusive.
- Reset asserted mid-drain takes effect at the next edge. It aborts the drain with no further writes and no write_done.

## Configuration
- WB_SATURATE_EN defined: each signed 2*datawith lane is clamped to the range [-2^(datawith-1), 2^(datawith-1)-1] before truncation. For datawith=16 that range is [-32768, 32767].
- WB_SATURATE_EN undefined: each lane is truncated to its low datawith bits (modular wrap).
- Latency is identical in both builds.

## Test plan
- Reset: drive rst=0 with arbitrary inputs → all outputs 0 and state IDLE. Release rst and assert row_valid=1 → row_ready stays 0 and no write occurs.
- Back-to-back drain: write_start with matrix_index=16, then row_valid held high with row r having every lane = r+1 → writes to addresses 16..23 on 8 consecutive cycles with every lane 1..8, then write_done exactly once, 11 cycles after write_start.
- Stalled source: row_valid toggles 1,0,0,1,… → exactly 8 writes at consecutive addresses, each one cycle after its handshake, and no write during gaps.
- Saturation: a row with lanes 0x0001_0000, 0xFFFF_0000, 0x0000_7FFF, 0xFFFF_8000:
  - with WB_SATURATE_EN → 0x7FFF, 0x8000, 0x7FFF, 0x8000
  - without it → 0x0000, 0x0000, 0x7FFF, 0x8000
- Ignored start: a second write_start pulse mid-drain → no restart, base unchanged, single write_done.
- Reset mid-operation: rst=0 after 3 rows → no further sram_write_enable and no write_done. A new write_start with matrix_index=40 → fresh drain at addresses 40..47.
